// File: rtl/sub_atr_pkg.sv
// Shared definitions for the pipelined subtractor.
//   SUB_WIDTH_DEF : default operand width
//   ovf_f         : signed-overflow rule for a subtraction, from the sign bits
//   sub_res_t     : result bundle {diff, bo, ovf, zero} at the default width
package sub_atr_pkg;

    localparam int SUB_WIDTH_DEF = 8;

    // a - b can only overflow when the operand signs differ; it has overflowed
    // when the result sign no longer matches the minuend sign.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    typedef struct packed {
        logic [SUB_WIDTH_DEF-1:0] diff;
        logic                     bo;
        logic                     ovf;
        logic                     zero;
    } sub_res_t;

endpackage

// File: rtl/sub_half_slice.sv
// Combinational W-bit subtract slice: {bout, d} = x - y - bin.
//   x, y : operands (W bits)
//   bin  : borrow-in
//   d    : difference modulo 2^W
//   bout : borrow-out, 1 iff x < y + bin
module sub_half_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] full;

    // One extra bit: a negative true result shows up as a set top bit.
    assign full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    assign d    = full[W-1:0];
    assign bout = full[W];

endmodule

// File: rtl/sub_atr_pipe_8.sv
// Two-stage pipelined subtractor: diff = a - b - bi (mod 2^WIDTH) with
// borrow-out, signed-overflow and zero flags, valid/ready on both sides.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake (a, b, bi)
//   out_valid/out_ready   : result handshake (diff, bo, ovf, zero)
// Stage 1 subtracts the low halves and carries the high halves forward;
// stage 2 subtracts the high halves using the stage-1 borrow.
// in_ready depends combinationally on out_ready; nothing on the input side
// reaches out_* without passing a register.
module sub_atr_pipe_8
    import sub_atr_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ovf,
    output logic             zero
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic            s1_valid;
    logic            s2_valid;
    logic            s1_load;
    logic            s2_load;

    logic [LO_W-1:0] s1_dlo;
    logic            s1_b1;
    logic [HI_W-1:0] s1_a_hi;
    logic [HI_W-1:0] s1_b_hi;

    logic [LO_W-1:0] lo_d;
    logic            lo_bout;
    logic [HI_W-1:0] hi_d;
    logic            hi_bout;

    sub_half_slice #(.W(LO_W)) u_lo (
        .x    (a[LO_W-1:0]),
        .y    (b[LO_W-1:0]),
        .bin  (bi),
        .d    (lo_d),
        .bout (lo_bout)
    );

    sub_half_slice #(.W(HI_W)) u_hi (
        .x    (s1_a_hi),
        .y    (s1_b_hi),
        .bin  (s1_b1),
        .d    (hi_d),
        .bout (hi_bout)
    );

    // Stage 2 drains into the output whenever it is empty or being consumed;
    // stage 1 can accept when it is empty or about to hand off to stage 2.
    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= s1_load | (s1_valid & ~s2_load);
            s2_valid <= s2_load | (s2_valid & ~out_ready);
        end
    end

    // Operand registers only capture on an accepted transfer, so undriven
    // inputs while in_valid is low never reach the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_dlo  <= '0;
            s1_b1   <= 1'b0;
            s1_a_hi <= '0;
            s1_b_hi <= '0;
        end else if (s1_load) begin
            s1_dlo  <= lo_d;
            s1_b1   <= lo_bout;
            s1_a_hi <= a[WIDTH-1:LO_W];
            s1_b_hi <= b[WIDTH-1:LO_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bo   <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (s2_load) begin
            diff <= {hi_d, s1_dlo};
            bo   <= hi_bout;
            ovf  <= ovf_f(s1_a_hi[HI_W-1], s1_b_hi[HI_W-1], hi_d[HI_W-1]);
            zero <= ({hi_d, s1_dlo} == '0);
        end
    end

endmodule
